// File: rtl/shift_mix_key_stage.sv
// Two-register elastic stage: ShiftRows into S1, then MixColumns (skipped on the
// last round) and AddRoundKey into S2. The tag rides along unchanged.
module shift_mix_key_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [127:0]     inState,
  input  logic [127:0]     inKey,
  input  logic             inLast,
  input  logic [TAG_W-1:0] inTag,
  output logic             outValid,
  input  logic             outReady,
  output logic [127:0]     outState,
  output logic [TAG_W-1:0] outTag,
  output logic             busy
);

  // Handshake: a beat moves on a rising edge where valid && ready. A producer
  // holds valid and its data until that edge; ready never depends on valid.

  logic             r_v1;
  logic [127:0]     r_sr;
  logic [127:0]     r_key;
  logic             r_last;
  logic [TAG_W-1:0] r_tag1;

  logic             r_v2;
  logic [127:0]     r_out;
  logic [TAG_W-1:0] r_tag2;

  logic             w_s2_free;
  logic             w_s1_move;
  logic             w_in_xfer;
  logic [127:0]     w_sr_next;
  logic [127:0]     w_mixed;
  logic [127:0]     w_s2_next;

  // Byte (r, c) lives at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] f_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] f_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] f_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = f_xtime(a0) ^ (f_xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ f_xtime(a1) ^ (f_xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ f_xtime(a2) ^ (f_xtime(a3) ^ a3);
    b3 = (f_xtime(a0) ^ a0) ^ a1 ^ a2 ^ f_xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] f_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = f_mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign w_s2_free = !r_v2 || outReady;
  assign w_s1_move = r_v1 && w_s2_free;
  assign inReady   = !r_v1 || w_s2_free;
  assign w_in_xfer = inValid && inReady;

  assign w_sr_next = f_shift_rows(inState);
  assign w_mixed   = f_mix_columns(r_sr);
  assign w_s2_next = (r_last ? r_sr : w_mixed) ^ r_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_sr   <= '0;
      r_key  <= '0;
      r_last <= 1'b0;
      r_tag1 <= '0;
    end else if (w_in_xfer) begin
      r_v1   <= 1'b1;
      r_sr   <= w_sr_next;
      r_key  <= inKey;
      r_last <= inLast;
      r_tag1 <= inTag;
    end else if (w_s1_move) begin
      r_v1 <= 1'b0;
    end
  end

  // S2 only changes when S1 hands over, so a stalled output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_out  <= '0;
      r_tag2 <= '0;
    end else if (w_s1_move) begin
      r_v2   <= 1'b1;
      r_out  <= w_s2_next;
      r_tag2 <= r_tag1;
    end else if (outReady) begin
      r_v2 <= 1'b0;
    end
  end

  assign outValid = r_v2;
  assign outState = r_out;
  assign outTag   = r_tag2;
  assign busy     = r_v1 | r_v2;

endmodule

// File: tb/tb_shift_mix_key_stage.sv
// Bench for shift_mix_key_stage: directed FIPS-197 vectors plus random traffic,
// checked by a queue scoreboard fed from a byte-matrix reference model.
module tb_shift_mix_key_stage;

  localparam int TAG_W = 4;
  localparam int W     = 128 + TAG_W;

  logic             clk;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [127:0]     inState;
  logic [127:0]     inKey;
  logic             inLast;
  logic [TAG_W-1:0] inTag;
  logic             outValid;
  logic             outReady;
  logic [127:0]     outState;
  logic [TAG_W-1:0] outTag;
  logic             busy;

  int tests_run = 0;
  int fail_cnt  = 0;
  int acc_cnt   = 0;

  logic [W-1:0] exp_q[$];

  logic             held_valid;
  logic [127:0]     held_state;
  logic [TAG_W-1:0] held_tag;

  shift_mix_key_stage #(.TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inState  (inState),
    .inKey    (inKey),
    .inLast   (inLast),
    .inTag    (inTag),
    .outValid (outValid),
    .outReady (outReady),
    .outState (outState),
    .outTag   (outTag),
    .busy     (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: state as a 4x4 byte matrix, GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
    logic [7:0] a[4][4];
    logic [7:0] b[4][4];
    logic [7:0] m[4][4];
    logic [7:0] coef[4];
    logic [127:0] o;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = s[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = a[r][(c+r)%4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m[r][c] = 8'h00;
        for (int j = 0; j < 4; j++)
          m[r][c] = m[r][c] ^ gmul(coef[(j-r+4)%4], b[j][c]);
      end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = (last ? b[r][c] : m[r][c]) ^ k[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard: push on accepted input, pop and compare on accepted output,
  // and hold stalled outputs against their previous value.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check("stall_valid", {127'd0, outValid}, 128'd1);
        check("stall_state", outState, held_state);
        check("stall_tag", {{(128-TAG_W){1'b0}}, outTag}, {{(128-TAG_W){1'b0}}, held_tag});
      end
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          fail_cnt++;
          $display("FAIL unexpected_beat: got state %h tag %0d, expected no beat", outState, outTag);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("out_state", outState, e[127:0]);
          check("out_tag", {{(128-TAG_W){1'b0}}, outTag}, {{(128-TAG_W){1'b0}}, e[W-1:128]});
        end
      end
      held_valid = outValid && !outReady;
      held_state = outState;
      held_tag   = outTag;
      if (inValid && inReady) begin
        exp_q.push_back({inTag, model_round(inState, inKey, inLast)});
        acc_cnt++;
      end
    end
  end

  // Driver tasks
  task automatic idle();
    inValid = 1'b0;
    inState = {$urandom, $urandom, $urandom, $urandom};
    inKey   = {$urandom, $urandom, $urandom, $urandom};
    inLast  = 1'($urandom_range(0, 1));
    inTag   = TAG_W'($urandom_range(0, 15));
  endtask

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                      input logic [TAG_W-1:0] t);
    bit acc;
    acc     = 1'b0;
    inValid = 1'b1;
    inState = s;
    inKey   = k;
    inLast  = l;
    inTag   = t;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      tests_run++;
      fail_cnt++;
      $display("FAIL send_timeout: got inReady 0 for 100 cycles, expected 1");
      inValid = 1'b0;
    end
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int ovh;
    int run;
    int max_run;
    int rdy_low;
    bit rand_done;

    rst_n    = 1'b0;
    outReady = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rst_outValid", {127'd0, outValid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_outState", outState, 128'd0);
    check("rst_outTag", {{(128-TAG_W){1'b0}}, outTag}, 128'd0);
    check("rst_inReady", {127'd0, inReady}, 128'd1);
    @(posedge clk);
    #1;

    // FIPS-197 round 1 with latency check
    outReady = 1'b1;
    send(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 4'd7);
    idle();
    check("fips_lat1_valid", {127'd0, outValid}, 128'd0);
    @(posedge clk);
    #1;
    check("fips_lat2_valid", {127'd0, outValid}, 128'd1);
    check("fips_state", outState, 128'ha49c7ff2689f352b6b5bea43026a5049);
    drain();

    // Last round: ShiftRows only
    send(128'h000102030405060708090a0b0c0d0e0f, 128'd0, 1'b1, 4'd3);
    idle();
    @(posedge clk);
    #1;
    check("last_state", outState, 128'h00050a0f04090e03080d02070c01060b);
    drain();

    // MixColumns vector (identical columns survive ShiftRows)
    send({4{32'hdb135345}}, 128'd0, 1'b0, 4'd9);
    idle();
    @(posedge clk);
    #1;
    check("mix_state", outState, {4{32'h8e4da1bc}});
    drain();

    // Backpressure: 6 stalled cycles while 5 beats are offered
    outReady = 1'b0;
    acc_cnt  = 0;
    fork
      begin
        for (int t = 1; t <= 5; t++)
          send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), TAG_W'(t));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("bp_inReady_low", {127'd0, inReady}, 128'd0);
        check("bp_accepts", 128'(acc_cnt), 128'd2);
        repeat (3) @(posedge clk);
        #1 outReady = 1'b1;
      end
    join
    drain();

    // Full-rate stream
    ovh = 0; run = 0; max_run = 0; rdy_low = 0;
    fork
      begin
        for (int t = 0; t < 8; t++)
          send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), TAG_W'(t));
        idle();
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (outValid) begin
            ovh++;
            run++;
            if (run > max_run) max_run = run;
          end else begin
            run = 0;
          end
          if (!inReady) rdy_low++;
        end
      end
    join
    check("stream_run", 128'(max_run), 128'd8);
    check("stream_valid_cycles", 128'(ovh), 128'd8);
    check("stream_inReady_low", 128'(rdy_low), 128'd0);
    drain();

    // Async reset with both registers full
    outReady = 1'b0;
    send(128'h1111, 128'h2222, 1'b0, 4'd1);
    send(128'h3333, 128'h4444, 1'b1, 4'd2);
    idle();
    check("pre_rst_busy", {127'd0, busy}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outValid", {127'd0, outValid}, 128'd0);
    check("arst_busy", {127'd0, busy}, 128'd0);
    check("arst_outState", outState, 128'd0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("arst_inReady", {127'd0, inReady}, 128'd1);
    outReady = 1'b1;
    ovh = 0;
    repeat (5) begin
      @(negedge clk);
      if (outValid) ovh++;
    end
    check("arst_no_stale", 128'(ovh), 128'd0);
    @(posedge clk);
    #1;

    // Random traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)));
          idle();
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          outReady = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
